pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have ports: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: we_i  input  1  bus write enable (`WriteEnable).
REQ-004 SHALL have ports: addr_i  input  32  bus address (`MemAddrBus); decode uses [23:20] group, [19:16] channel.
REQ-005 SHALL have ports: data_i  input  32  write data (`MemBus).
REQ-006 SHALL have ports: data_o  output  32  read data (`MemBus), combinational from addr_i.
REQ-007 SHALL have ports: pwm_in  input  4  asynchronous PWM inputs, one per channel.
REQ-008 SHALL have ports: irq_o  output  1  capture interrupt, level, active-high.

Function
REQ-009 Register map by addr_i[23:20], with ch = addr_i[19:16] in 0..3: 0 = PERIOD[ch] (RO); 1 = HIGH[ch] (RO); 2 = CTRL (RW), [3:0] enable and [7:4] irq mask; 3 = STATUS, [3:0] valid and [7:4] timeout, write-1-to-clear.
REQ-010 Reads of unmapped groups or ch > 3 SHALL return `ZeroWord; writes to them and to RO registers SHALL be ignored.
REQ-011 Each pwm_in bit SHALL pass a 2-flop synchronizer, then a registered edge detector. A pin edge SHALL be detected on the 3rd clk edge after it settles.
REQ-012 Per channel FSM states: IDLE, ARM, MEAS.
REQ-013 FSM transitions:
- IDLE to ARM when the enable bit is 1.
- ARM to MEAS on a detected rising edge, with cnt <= 1.
- MEAS to IDLE when the enable bit is 0, from any state.
REQ-014 In MEAS, cnt SHALL increment by 1 every cycle.
REQ-015 On a detected falling edge in MEAS: HIGH[ch] <= cnt.
REQ-016 On a detected rising edge in MEAS:
- PERIOD[ch] <= cnt.
- valid[ch] <= 1.
- cnt <= 1.
REQ-017 PERIOD and HIGH SHALL be in clk cycles, 32-bit unsigned, and measured between detected edges.
REQ-018 When cnt reaches `PwmCapMax without a rising edge: timeout[ch] <= 1, go to ARM, cnt <= 0. PERIOD and HIGH SHALL hold their values.
REQ-019 Disabling a channel mid-measurement SHALL clear cnt. PERIOD, HIGH and STATUS SHALL be retained.
REQ-020 If a hardware set and a W1C clear of the same STATUS bit occur in one cycle, the set SHALL win.
REQ-021 CTRL and STATUS writes SHALL take effect on the next clk edge.

Reset
REQ-022 While rst = 0, asynchronously, the block SHALL set: all FSMs to IDLE; cnt, PERIOD, HIGH, CTRL, STATUS, synchronizer and edge flops to 0; irq_o = 0.
REQ-023 The synchronizer SHALL resample after rst deasserts. No edge SHALL be reported for the first 2 cycles after reset.

Configuration
REQ-024 Macro PWM_CAPTURE_IRQ_EN:
- When defined: irq_o is a registered |((valid | timeout) & mask).
- When undefined: irq_o is tied 0, and CTRL[7:4] reads 0 and ignores writes.

Structure
REQ-025 The shared defines file SHALL hold:
- `PwmCapMax, default 32'h00FF_FFFF, overridable for simulation.
- Group codes `PwmCapGrpPeriod, `PwmCapGrpHigh, `PwmCapGrpCtrl, `PwmCapGrpStat.
- FSM state encodings.
REQ-026 There SHALL be one sub-module, pwm_capture_chan, instantiated 4 times. It holds the synchronizer, edge detect, FSM, cnt, PERIOD and HIGH, and outputs valid and timeout set pulses.

Verification
REQ-027 Enable ch0 (CTRL = 0x1); pwm_in[0] period 10, high 3 (cycles): read 0x0000_0000 returns 10; read 0x0010_0000 returns 3; STATUS[0] = 1.
REQ-028 Write STATUS = 0x1 in the same cycle as a new ch0 rising edge: STATUS[0] stays 1.
REQ-029 Set `PwmCapMax = 100 and hold pwm_in[1] high after one rising edge: STATUS[5] = 1 after 100 cycles; PERIOD[1] holds its prior value.
REQ-030 Clear CTRL[2] mid-period on ch2: FSM goes to IDLE; re-enable, and the first capture completes only after 2 rising edges.
REQ-031 Assert rst mid-capture without a clk edge: all outputs 0 immediately; data_o reads 0 at every address.
REQ-032 With PWM_CAPTURE_IRQ_EN and CTRL = 0x13: irq_o rises 1 cycle after STATUS[0] sets; W1C of STATUS[0] drops irq_o on the next cycle.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg -- shared definitions for the PWM capture block.
//
// Holds the project-wide defines (capture limit, register group codes,
// channel FSM encodings) and the package that turns them into typed
// localparams and the channel state enum.
//
// Defines:
//   `PwmCapMax        counter limit before a channel reports a timeout
//   `ZeroWord         value returned for unmapped reads
//   `PwmCapGrpPeriod  addr[23:20] code of the PERIOD registers
//   `PwmCapGrpHigh    addr[23:20] code of the HIGH registers
//   `PwmCapGrpCtrl    addr[23:20] code of CTRL
//   `PwmCapGrpStat    addr[23:20] code of STATUS
//   `PwmCapStIdle/Arm/Meas  channel FSM state encodings
//
// Optional feature macro used by the block: PWM_CAPTURE_IRQ_EN.

`ifndef PwmCapMax
`define PwmCapMax 32'h00FF_FFFF
`endif

`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

`ifndef PwmCapGrpPeriod
`define PwmCapGrpPeriod 4'h0
`endif

`ifndef PwmCapGrpHigh
`define PwmCapGrpHigh 4'h1
`endif

`ifndef PwmCapGrpCtrl
`define PwmCapGrpCtrl 4'h2
`endif

`ifndef PwmCapGrpStat
`define PwmCapGrpStat 4'h3
`endif

`ifndef PwmCapStIdle
`define PwmCapStIdle 2'd0
`endif

`ifndef PwmCapStArm
`define PwmCapStArm 2'd1
`endif

`ifndef PwmCapStMeas
`define PwmCapStMeas 2'd2
`endif

package pwm_capture_pkg;

    localparam int          NUM_CH      = 4;
    localparam logic [31:0] PWM_CAP_MAX = `PwmCapMax;
    localparam logic [31:0] ZERO_WORD   = `ZeroWord;

    localparam logic [3:0] GRP_PERIOD = `PwmCapGrpPeriod;
    localparam logic [3:0] GRP_HIGH   = `PwmCapGrpHigh;
    localparam logic [3:0] GRP_CTRL   = `PwmCapGrpCtrl;
    localparam logic [3:0] GRP_STAT   = `PwmCapGrpStat;

    typedef enum logic [1:0] {
        ST_IDLE = `PwmCapStIdle,
        ST_ARM  = `PwmCapStArm,
        ST_MEAS = `PwmCapStMeas
    } chan_state_e;

    // Channel field of the address selects one of the four channels; any
    // larger value is treated as an unmapped location.
    function automatic logic chan_in_range(input logic [3:0] ch);
        return (ch < 4'(NUM_CH));
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if -- simple register bus used to reach the PWM capture block.
//
// Signals:
//   we_i    write enable (one cycle per write)
//   addr_i  byte address; [23:20] group, [19:16] channel
//   data_i  write data
//   data_o  read data, combinational from addr_i
//
// Modports: master (bus driver), slave (pwm_capture).

interface pwm_capture_if;

    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output we_i,
        output addr_i,
        output data_i,
        input  data_o
    );

    modport slave (
        input  we_i,
        input  addr_i,
        input  data_i,
        output data_o
    );

endinterface

// File: rtl/pwm_capture_chan.sv
// pwm_capture_chan -- one PWM measurement channel.
//
// Synchronizes an asynchronous PWM pin, detects its edges and measures the
// period (rising to rising) and high time (rising to falling) in clk cycles.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   pwm_in         asynchronous PWM pin
//   enable         channel enable from CTRL
//   period_o       last captured period
//   high_o         last captured high time
//   valid_set_o    one-cycle pulse: a new period was captured
//   timeout_set_o  one-cycle pulse: no rising edge within CNT_MAX cycles

module pwm_capture_chan
    import pwm_capture_pkg::*;
#(
    parameter logic [31:0] CNT_MAX = PWM_CAP_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    input  logic        enable,
    output logic [31:0] period_o,
    output logic [31:0] high_o,
    output logic        valid_set_o,
    output logic        timeout_set_o
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        edge_q,  edge_d;
    logic        rise;
    logic        fall;

    chan_state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic [31:0] high_q, high_d;

    // Two synchronizer flops followed by one history flop. Comparing the
    // synchronized level with its history yields edge strobes that the FSM
    // consumes on the third clock edge after the pin settles.
    always_comb begin
        sync1_d = pwm_in;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
        end
    end

    assign rise = sync2_q & ~edge_q;
    assign fall = ~sync2_q & edge_q;

    // Measurement FSM. cnt holds the number of cycles since the last
    // detected rising edge, so its value at the next edge is the interval.
    // A disabled channel drops to IDLE from any state and forgets cnt, but
    // the captured PERIOD/HIGH values are kept for software to read.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        high_d        = high_q;
        valid_set_o   = 1'b0;
        timeout_set_o = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    cnt_d   = 32'd0;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_MEAS;
                        cnt_d   = 32'd1;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        period_d    = cnt_q;
                        valid_set_o = 1'b1;
                        cnt_d       = 32'd1;
                    end else if (cnt_q >= CNT_MAX) begin
                        // Pin stuck: report it and wait for a fresh rising edge.
                        timeout_set_o = 1'b1;
                        state_d       = ST_ARM;
                        cnt_d         = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                        if (fall) begin
                            high_d = cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 32'd0;
            period_q <= 32'd0;
            high_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            high_q   <= high_d;
        end
    end

    assign period_o = period_q;
    assign high_o   = high_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture -- four-channel PWM period / high-time capture unit.
//
// Each channel measures its PWM input in clk cycles; software reads the
// results and status through a small register bus.
//
// Register map (addr[23:20] group, addr[19:16] channel 0..3):
//   0  PERIOD[ch]  RO
//   1  HIGH[ch]    RO
//   2  CTRL        RW  [3:0] enable, [7:4] irq mask
//   3  STATUS      W1C [3:0] valid, [7:4] timeout
// Unmapped locations read zero and ignore writes.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous reset, active low
//   bus     register bus (pwm_capture_if.slave)
//   pwm_in  asynchronous PWM inputs, one per channel
//   irq_o   level interrupt, active high
//
// Build option: define PWM_CAPTURE_IRQ_EN to enable the interrupt; without
// it irq_o is tied low and the CTRL mask field reads zero.

module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter logic [31:0] CNT_MAX = PWM_CAP_MAX
) (
    input  logic         clk,
    input  logic         rst,
    pwm_capture_if.slave bus,
    input  logic [3:0]   pwm_in,
    output logic         irq_o
);

    logic [3:0]  grp;
    logic [3:0]  ch;
    logic        reg_we;
    logic        unused_bus;

    logic [31:0] period_w [NUM_CH];
    logic [31:0] high_w   [NUM_CH];
    logic [3:0]  valid_set;
    logic [3:0]  timeout_set;

    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  status_clr;

    assign grp        = bus.addr_i[23:20];
    assign ch         = bus.addr_i[19:16];
    assign reg_we     = bus.we_i && chan_in_range(ch);
    assign unused_bus = ^{bus.addr_i[31:24], bus.addr_i[15:0], bus.data_i[31:8]};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        pwm_capture_chan #(
            .CNT_MAX (CNT_MAX)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .pwm_in        (pwm_in[i]),
            .enable        (ctrl_q[i]),
            .period_o      (period_w[i]),
            .high_o        (high_w[i]),
            .valid_set_o   (valid_set[i]),
            .timeout_set_o (timeout_set[i])
        );
    end

    // Read mux, purely combinational from the address.
    always_comb begin
        bus.data_o = ZERO_WORD;
        if (chan_in_range(ch)) begin
            case (grp)
                GRP_PERIOD: bus.data_o = period_w[ch[1:0]];
                GRP_HIGH:   bus.data_o = high_w[ch[1:0]];
                GRP_CTRL:   bus.data_o = {24'h0, ctrl_q};
                GRP_STAT:   bus.data_o = {24'h0, status_q};
                default:    bus.data_o = ZERO_WORD;
            endcase
        end
    end

    // CTRL write. Without the interrupt option the mask bits are not stored.
    always_comb begin
        ctrl_d = ctrl_q;
        if (reg_we && (grp == GRP_CTRL)) begin
            ctrl_d = bus.data_i[7:0];
        end
`ifndef PWM_CAPTURE_IRQ_EN
        ctrl_d[7:4] = 4'h0;
`endif
    end

    // STATUS: write-1-to-clear, but a hardware set in the same cycle is
    // applied after the clear so the event is never lost.
    always_comb begin
        status_clr = 8'h00;
        if (reg_we && (grp == GRP_STAT)) begin
            status_clr = bus.data_i[7:0];
        end
        status_d = (status_q & ~status_clr) | {timeout_set, valid_set};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q   <= 8'h00;
            status_q <= 8'h00;
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
        end
    end

`ifdef PWM_CAPTURE_IRQ_EN
    logic irq_q, irq_d;

    // A channel raises the interrupt while its valid or timeout flag is set
    // and its mask bit is on.
    always_comb begin
        irq_d = |((status_q[3:0] | status_q[7:4]) & ctrl_q[7:4]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture -- self-checking bench for pwm_capture.
//
// Drives PWM waveforms and register accesses, and compares the DUT against
// a timestamp-based reference model: each channel remembers the cycle of
// its last detected rising edge, and periods / high times are differences
// of cycle numbers. Pin edges become visible to the model two samples after
// the pin is driven, matching the synchronized edge detection.

`timescale 1ns/1ps

module tb_pwm_capture;

    localparam logic [31:0] SIM_MAX = 32'd100;

`ifdef PWM_CAPTURE_IRQ_EN
    localparam logic [7:0] CTRL_KEEP = 8'hFF;
`else
    localparam logic [7:0] CTRL_KEEP = 8'h0F;
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic [3:0] pwm_in = 4'h0;
    logic       irq_o;

    int total = 0;
    int bad   = 0;

    pwm_capture_if bus ();

    pwm_capture #(
        .CNT_MAX (SIM_MAX)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .pwm_in (pwm_in),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    // ---------------- waveform generators ----------------
    int unsigned gen_per   [4] = '{10, 10, 10, 10};
    int unsigned gen_high  [4] = '{3, 3, 3, 3};
    int unsigned gen_phase [4] = '{0, 0, 0, 0};
    bit          gen_run   [4] = '{0, 0, 0, 0};
    bit          gen_hold  [4] = '{0, 0, 0, 0};

    // ---------------- reference model ----------------
    int unsigned k_now = 0;
    int          md        [4] = '{0, 0, 0, 0};   // 0 off, 1 waiting for first rise, 2 timing
    int unsigned rise_k    [4] = '{0, 0, 0, 0};
    logic [31:0] m_period  [4] = '{0, 0, 0, 0};
    logic [31:0] m_high    [4] = '{0, 0, 0, 0};
    logic [7:0]  m_ctrl   = 8'h00;
    logic [7:0]  m_status = 8'h00;
    logic        m_irq    = 1'b0;
    logic [3:0]  p1 = 4'h0, p2 = 4'h0, p3 = 4'h0;   // pin samples 1, 2, 3 edges ago
    logic [3:0]  m_rise, m_fall, m_vset, m_tset;
    logic [7:0]  m_clr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) begin
                md[c]       = 0;
                rise_k[c]   = 0;
                m_period[c] = 32'h0;
                m_high[c]   = 32'h0;
            end
            m_ctrl   = 8'h00;
            m_status = 8'h00;
            m_irq    = 1'b0;
            p1 = 4'h0; p2 = 4'h0; p3 = 4'h0;
        end else begin
            m_rise = p2 & ~p3;
            m_fall = ~p2 & p3;
            m_vset = 4'h0;
            m_tset = 4'h0;
            for (int c = 0; c < 4; c++) begin
                if (!m_ctrl[c]) begin
                    md[c] = 0;
                end else if (md[c] == 0) begin
                    md[c] = 1;
                end else if (md[c] == 1) begin
                    if (m_rise[c]) begin
                        md[c]     = 2;
                        rise_k[c] = k_now;
                    end
                end else begin
                    if (m_rise[c]) begin
                        m_period[c] = k_now - rise_k[c];
                        m_vset[c]   = 1'b1;
                        rise_k[c]   = k_now;
                    end else if (k_now - rise_k[c] >= SIM_MAX) begin
                        m_tset[c] = 1'b1;
                        md[c]     = 1;
                    end else if (m_fall[c]) begin
                        m_high[c] = k_now - rise_k[c];
                    end
                end
            end
            m_irq = |((m_status[3:0] | m_status[7:4]) & m_ctrl[7:4]);
            m_clr = 8'h00;
            if (bus.we_i && (bus.addr_i[19:16] < 4'd4)) begin
                if (bus.addr_i[23:20] == 4'h2) m_ctrl = bus.data_i[7:0] & CTRL_KEEP;
                if (bus.addr_i[23:20] == 4'h3) m_clr  = bus.data_i[7:0];
            end
            m_status = (m_status & ~m_clr) | {m_tset, m_vset};
            p3 = p2;
            p2 = p1;
            p1 = pwm_in;
            k_now++;
        end
    end

    function automatic logic [31:0] addr_of(input int g, input int c);
        return {8'h00, 4'(g), 4'(c), 16'h0000};
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [3:0] g;
        logic [3:0] c;
        g = a[23:20];
        c = a[19:16];
        if (c > 4'd3) return 32'h0;
        case (g)
            4'h0:    return m_period[c[1:0]];
            4'h1:    return m_high[c[1:0]];
            4'h2:    return {24'h0, m_ctrl};
            4'h3:    return {24'h0, m_status};
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- tasks ----------------
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkRead(input string tag, input logic [31:0] addr);
        bus.addr_i = addr;
        #1;
        checkOutput(tag, bus.data_o, exp_read(addr));
    endtask

    // One clock cycle: drive the bus and the next waveform sample, then
    // return at the following falling edge with the write strobe dropped.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus.we_i   = we;
        bus.addr_i = addr;
        bus.data_i = data;
        for (int c = 0; c < 4; c++) begin
            if (gen_run[c]) begin
                pwm_in[c]    = (gen_phase[c] < gen_high[c]);
                gen_phase[c] = (gen_phase[c] + 1) % gen_per[c];
            end else begin
                pwm_in[c] = gen_hold[c];
            end
        end
        @(posedge clk);
        @(negedge clk);
        bus.we_i = 1'b0;
    endtask

    task automatic runCycles(input int n);
        repeat (n) applyStimulus(1'b0, bus.addr_i, 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] ctrl_val;
    logic [31:0] saved_period;

    initial begin
        bus.we_i   = 1'b0;
        bus.addr_i = 32'h0;
        bus.data_i = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        checkRead("rst_period0", addr_of(0, 0));
        checkRead("rst_ctrl", addr_of(2, 0));
        checkRead("rst_status", addr_of(3, 0));
        checkOutput("rst_irq", {31'b0, irq_o}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        $display("[TB] reset released");

        // Basic capture on ch0: period 10, high 3
        gen_per[0] = 10; gen_high[0] = 3; gen_phase[0] = 0; gen_run[0] = 1;
        applyStimulus(1'b1, addr_of(2, 0), 32'h1);
        runCycles(45);
        checkRead("ch0_period", addr_of(0, 0));
        checkOutput("ch0_period_const", bus.data_o, 32'd10);
        checkRead("ch0_high", addr_of(1, 0));
        checkOutput("ch0_high_const", bus.data_o, 32'd3);
        runCycles(1);
        checkRead("ch0_status", addr_of(3, 0));
        checkOutput("ch0_valid_const", {31'b0, bus.data_o[0]}, 32'd1);
        checkRead("ctrl_read", addr_of(2, 0));
        checkRead("unmapped_ch", addr_of(0, 5));
        checkOutput("unmapped_ch_const", bus.data_o, 32'h0);
        runCycles(1);

        // W1C landing on the same cycle as a new rising edge: the set wins
        gen_run[0] = 0; gen_hold[0] = 0;
        runCycles(12);
        applyStimulus(1'b1, addr_of(3, 0), 32'h1);
        checkRead("w1c_cleared", addr_of(3, 0));
        checkOutput("w1c_cleared_const", {31'b0, bus.data_o[0]}, 32'd0);
        gen_hold[0] = 1;
        applyStimulus(1'b0, bus.addr_i, 32'h0);
        applyStimulus(1'b0, bus.addr_i, 32'h0);
        applyStimulus(1'b1, addr_of(3, 0), 32'h1);
        checkRead("setwins_status", addr_of(3, 0));
        checkOutput("setwins_const", {31'b0, bus.data_o[0]}, 32'd1);
        checkRead("setwins_period", addr_of(0, 0));
        runCycles(1);

        // Randomized waveforms on all channels with random W1C traffic
        for (int c = 0; c < 4; c++) begin
            gen_per[c]   = $urandom_range(30, 4);
            gen_high[c]  = $urandom_range(gen_per[c] - 1, 1);
            gen_phase[c] = 0;
            gen_run[c]   = 1;
        end
        ctrl_val = 32'hFF;
        applyStimulus(1'b1, addr_of(2, 0), ctrl_val);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(7) == 0)
                applyStimulus(1'b1, addr_of(3, 0), 32'($urandom_range(255)));
            else
                applyStimulus(1'b0, bus.addr_i, 32'h0);
            checkOutput("irq_rand", {31'b0, irq_o}, {31'b0, m_irq});
        end
        for (int c = 0; c < 4; c++) begin
            checkRead("rand_period", addr_of(0, c));
            checkOutput("rand_period_const", bus.data_o, gen_per[c]);
            checkRead("rand_high", addr_of(1, c));
            checkOutput("rand_high_const", bus.data_o, gen_high[c]);
            runCycles(1);
        end
        checkRead("rand_status", addr_of(3, 0));
        checkRead("rand_ctrl", addr_of(2, 1));
        checkRead("unmapped_grp", addr_of(5, 0));
        runCycles(1);

        // Timeout on ch1: one rising edge, then the pin stays high
        gen_run[1] = 0; gen_hold[1] = 0;
        applyStimulus(1'b1, addr_of(3, 0), 32'h20);
        runCycles(3);
        gen_hold[1] = 1;
        runCycles(3);
        saved_period = m_period[1];
        for (int i = 0; i < 104; i++) begin
            applyStimulus(1'b0, bus.addr_i, 32'h0);
            checkRead("timeout_model", addr_of(3, 0));
            checkOutput("timeout_at_limit", {31'b0, bus.data_o[5]}, {31'b0, (i >= 99)});
        end
        checkRead("timeout_period_model", addr_of(0, 1));
        checkOutput("timeout_period_hold", bus.data_o, saved_period);
        gen_phase[1] = 0; gen_run[1] = 1;
        runCycles(1);

        // Disable ch2 mid-period, then re-enable: two rises before capture
        applyStimulus(1'b1, addr_of(3, 0), 32'h04);
        runCycles($urandom_range(10, 3));
        applyStimulus(1'b1, addr_of(2, 0), ctrl_val & ~32'h4);
        runCycles(5);
        applyStimulus(1'b1, addr_of(3, 0), 32'h04);
        checkRead("dis_status", addr_of(3, 0));
        applyStimulus(1'b1, addr_of(2, 0), ctrl_val);
        for (int i = 0; i < int'(2 * gen_per[2] + 12); i++) begin
            applyStimulus(1'b0, bus.addr_i, 32'h0);
            checkRead("reen_status", addr_of(3, 0));
        end
        checkRead("reen_period", addr_of(0, 2));
        checkOutput("reen_period_const", bus.data_o, gen_per[2]);
        runCycles(1);

        // Interrupt path with ch0/ch1 enabled and only ch0 unmasked
        applyStimulus(1'b1, addr_of(2, 0), 32'h13);
        applyStimulus(1'b1, addr_of(3, 0), 32'hFF);
        checkRead("ctrl_13", addr_of(2, 0));
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, bus.addr_i, 32'h0);
            checkOutput("irq_track", {31'b0, irq_o}, {31'b0, m_irq});
        end
        applyStimulus(1'b1, addr_of(3, 0), 32'h01);
        checkOutput("irq_after_w1c", {31'b0, irq_o}, {31'b0, m_irq});
        applyStimulus(1'b0, bus.addr_i, 32'h0);
        checkOutput("irq_next", {31'b0, irq_o}, {31'b0, m_irq});
        applyStimulus(1'b1, addr_of(2, 0), 32'h0F);
        runCycles(40);

        // Asynchronous reset between clock edges
        bus.addr_i = addr_of(0, 0);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("arst_irq", {31'b0, irq_o}, 32'h0);
        checkOutput("arst_period0", bus.data_o, 32'h0);
        checkRead("arst_high0", addr_of(1, 0));
        checkRead("arst_ctrl", addr_of(2, 0));
        checkOutput("arst_ctrl_const", bus.data_o, 32'h0);
        @(negedge clk);
        checkRead("arst_status", addr_of(3, 0));
        checkOutput("arst_status_const", bus.data_o, 32'h0);
        checkRead("arst_period3", addr_of(0, 3));
        checkOutput("arst_period3_const", bus.data_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
